uart_rx_oversampled: RTL and testbench

//   Serial front end of the host-to-plotter command link: recovers 8N1 UART bytes from the rx pin.

---
 rtl/uart_rx_oversampled.sv | 155 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with 2-flop input synchroniser, 3-sample majority vote per bit,
// false-start rejection and framing-error detection.
module uart_rx_oversampled #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       data_ready,
  output logic [7:0] q,
  output logic       framing_error,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int M     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(M);
  localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(M + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic             rx_meta_q, rx_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_q, byte_d;
  logic             smp_a_q, smp_a_d;
  logic             smp_b_q, smp_b_d;
  logic             data_ready_q, data_ready_d;
  logic             framing_error_q, framing_error_d;

  logic at_last, decide, bit_v;

  // Sync flops reset to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two flops a true 2-stage pipeline.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign at_last = (cnt_q == CNT_LAST);
  assign decide  = (cnt_q == SMP_C);
  assign bit_v   = (smp_a_q & smp_b_q) | (smp_a_q & rx_s_q) | (smp_b_q & rx_s_q);

  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    shreg_d         = shreg_q;
    byte_d          = byte_q;
    smp_a_d         = smp_a_q;
    smp_b_d         = smp_b_q;
    data_ready_d    = 1'b0;
    framing_error_d = 1'b0;

    if (state_q == START || state_q == DATA || state_q == STOP) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
      if (cnt_q == SMP_A) smp_a_d = rx_s_q;
      if (cnt_q == SMP_B) smp_b_d = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // The detect cycle is cnt 0 of the start-bit window.
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = CNT_W'(1);
        end
      end
      START: begin
        if (decide && bit_v) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (at_last) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (decide) shreg_d = {bit_v, shreg_q[7:1]};
        if (at_last) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at the decision point so a back-to-back start bit is not missed.
        if (decide) begin
          cnt_d = '0;
          if (bit_v) begin
            byte_d       = shreg_q;
            data_ready_d = 1'b1;
            state_d      = IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shreg_q         <= '0;
      byte_q          <= '0;
      smp_a_q         <= 1'b1;
      smp_b_q         <= 1'b1;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shreg_q         <= shreg_d;
      byte_q          <= byte_d;
      smp_a_q         <= smp_a_d;
      smp_b_q         <= smp_b_d;
      data_ready_q    <= data_ready_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign data_ready    = data_ready_q;
  assign framing_error = framing_error_q;
  assign q             = byte_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboarded bench for uart_rx_oversampled: table of frames plus hand-written
// sequences for false start, framing error with line break, and mid-frame reset.
module tb_uart_rx_oversampled;

  localparam int CPB     = 16;
  localparam int M       = CPB / 2;
  localparam int LATENCY = 2 + 9 * CPB + M + 2;  // pin fall to data_ready

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       data_ready;
  logic [7:0] q;
  logic       framing_error;
  logic       busy;

  longint cyc = 0;
  int     total = 0;
  int     bad = 0;

  typedef struct {
    logic       is_fe;
    logic [7:0] data;
    longint     exp_cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       spike;
    int         gap_bits;
    logic       exp_fe;
    logic [7:0] exp_q;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[4];

  uart_rx_oversampled #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data_ready   (data_ready),
    .q            (q),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic v, input logic spike);
    for (int c = 0; c < CPB; c++) begin
      @(negedge clk);
      rx = (spike && c == M) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic spike,
                            input logic push, input logic exp_fe, input logic [7:0] exp_q);
    ev_t ev;
    @(negedge clk);
    rx = 1'b0;
    if (push) begin
      ev.is_fe   = exp_fe;
      ev.data    = exp_q;
      ev.exp_cyc = cyc + LATENCY;
      sb.push_back(ev);
    end
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], spike);
    drive_bit(stop_bit, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 * CPB; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check(name, sb.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every pulse, checks q holds otherwise.
  initial begin
    ev_t        ev;
    logic [7:0] prev_q = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        prev_q = q;
      end else if (data_ready || framing_error) begin
        check("dr_fe_exclusive", {31'd0, data_ready & framing_error}, 0);
        check("sb_nonempty", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          ev = sb.pop_front();
          check("event_kind_fe", {31'd0, framing_error}, {31'd0, ev.is_fe});
          check("event_cycle", 32'(cyc), 32'(ev.exp_cyc));
          if (data_ready) begin
            check("q_value", {24'd0, q}, {24'd0, ev.data});
            check("busy_at_dr", {31'd0, busy}, 0);
          end else begin
            check("q_on_fe", {24'd0, q}, {24'd0, prev_q});
          end
        end
        prev_q = q;
      end else begin
        if (q !== prev_q) check("q_hold", {24'd0, q}, {24'd0, prev_q});
        prev_q = q;
      end
    end
  end

  initial begin
    logic [7:0] c3;
    vecs[0] = '{data: 8'h41, stop_bit: 1'b1, spike: 1'b0, gap_bits: 2, exp_fe: 1'b0, exp_q: 8'h41};
    vecs[1] = '{data: 8'h0A, stop_bit: 1'b1, spike: 1'b0, gap_bits: 0, exp_fe: 1'b0, exp_q: 8'h0A};
    vecs[2] = '{data: 8'h0B, stop_bit: 1'b1, spike: 1'b0, gap_bits: 2, exp_fe: 1'b0, exp_q: 8'h0B};
    vecs[3] = '{data: 8'hF0, stop_bit: 1'b1, spike: 1'b1, gap_bits: 3, exp_fe: 1'b0, exp_q: 8'hF0};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_ready", {31'd0, data_ready}, 0);
    check("rst_framing_error", {31'd0, framing_error}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_q", {24'd0, q}, 0);
    reset = 1'b0;
    idle(4);

    // Good frames, back-to-back pair, and spike-per-bit majority vote.
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].spike, 1'b1, vecs[i].exp_fe, vecs[i].exp_q);
      idle(vecs[i].gap_bits * CPB);
    end
    drain("drain_table");

    // Short low glitch in IDLE: START must fall back to IDLE with no output.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    check("glitch_busy_start", {31'd0, busy}, 1);
    idle(2 * CPB);
    check("glitch_busy_idle", {31'd0, busy}, 0);
    check("glitch_q_kept", {24'd0, q}, 32'h0000_00F0);

    // Framing error followed by a 40-bit line break, then a good byte.
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int b = 0; b < 40; b++) begin
      drive_bit(1'b0, 1'b0);
      check("break_busy", {31'd0, busy}, 1);
    end
    idle(2 * CPB);
    check("break_end_busy", {31'd0, busy}, 0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
    idle(2 * CPB);
    drain("drain_break");

    // Reset during data bit 4 of 0xC3 drops the partial byte.
    c3 = 8'hC3;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(c3[i], 1'b0);
    for (int c = 0; c < M; c++) begin
      @(negedge clk);
      rx = c3[4];
    end
    check("midframe_busy", {31'd0, busy}, 1);
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    #1;
    check("mid_rst_data_ready", {31'd0, data_ready}, 0);
    check("mid_rst_framing_error", {31'd0, framing_error}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_q", {24'd0, q}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2 * CPB);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3);
    idle(2 * CPB);
    drain("drain_reset");

    check("final_q", {24'd0, q}, 32'h0000_00C3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
